// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. The asynchronous rxd pin passes through a 2-flop
// synchronizer. The FSM then samples each bit at its centre. Each good byte
// lands in a 1-entry valid/ready holding register.
//
// Ports
//   clk        system clock, sole clock
//   rst        asynchronous, active-high reset
//   rxd        serial input, idle high, asynchronous to clk
//   rx_data    received byte, valid while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer accepts the byte when rx_valid & rx_ready at a clk edge
//   frame_err  1-cycle pulse: the stop bit was sampled as 0
//   overrun    1-cycle pulse: a good byte was dropped because the holding register was full
//   busy       1 whenever the FSM is not IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on rxs
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per CLKDIV cycles
// STOP  | sampling the stop bit; a 1 delivers the byte, a 0 is a framing error
// BRK   | after a framing error, waiting for the line to return high
module uart_rx #(
  parameter int CLKDIV = 938
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          sync1, rxs;
  logic          good_frame, bad_frame;

  // The synchronizer resets to the idle line level, so a reset release is never
  // mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shreg_nxt  = shreg;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end

      START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt = '0;
          if (rxs) begin
            // The line went back high before mid-bit: treat it as a glitch.
            state_nxt = IDLE;
          end else begin
            idx_nxt   = '0;
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == FULL_TC) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rxs;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      STOP: begin
        if (cnt == FULL_TC) begin
          cnt_nxt = '0;
          if (rxs) begin
            good_frame = 1'b1;
            state_nxt  = IDLE;
          end else begin
            bad_frame  = 1'b1;
            state_nxt  = BRK;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      BRK: begin
        if (rxs) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A consumer accepting in the same cycle as a new byte frees the slot. That
  // byte then replaces the old one instead of being counted as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      overrun   <= 1'b0;
      if (good_frame) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx with CLKDIV=16. Frames are driven onto rxd at
// 16 clk per bit. A negedge monitor counts error pulses and rx_valid rising
// edges, and it queues every byte that is accepted through the handshake.
module tb_uart_rx;

  localparam int CLKDIV = 16;
  localparam int LAT    = 2 + CLKDIV / 2 + 9 * CLKDIV + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vrise  = 0;
  int vrise_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] acc_q[$];

  uart_rx #(.CLKDIV(CLKDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && !prev_v) begin
      vrise++;
      vrise_cyc = cyc;
    end
    prev_v = rx_valid;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      wait_cyc(CLKDIV);
    end
  endtask

  // The frame is {stop, data[7:0], start=0}, sent LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits({stop, b, 1'b0}, 10);
  endtask

  task automatic accept_pulse();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[5];
  int fe0, ov0, vr0, st;
  logic [7:0] exp_b;

  initial begin
    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF};
    vecs[2] = '{8'h81, 8'h81};
    vecs[3] = '{8'h5A, 8'h5A};
    vecs[4] = '{8'hC3, 8'hC3};

    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(5);

    // 1: single frame 0x55, consumer not ready, then one accept pulse.
    vr0 = vrise;
    st = cyc;
    send_frame(8'h55, 1'b1);
    wait_cyc(4);
    chk("t1 rx_valid", rx_valid, 1);
    chk("t1 rx_data", rx_data, 8'h55);
    chk("t1 valid count", vrise - vr0, 1);
    chk("t1 latency", vrise_cyc - st, LAT);
    accept_pulse();
    chk("t1 valid after accept", rx_valid, 0);
    chk("t1 data held", rx_data, 8'h55);
    wait_cyc(3);

    // 2: a 4-cycle low glitch is rejected at mid-start-bit.
    fe0 = fe_cnt;
    vr0 = vrise;
    rxd = 1'b0;
    wait_cyc(4);
    chk("t2 busy during glitch", busy, 1);
    rxd = 1'b1;
    wait_cyc(20);
    chk("t2 busy after glitch", busy, 0);
    chk("t2 no valid", vrise - vr0, 0);
    chk("t2 no frame_err", fe_cnt - fe0, 0);

    // 3: 0xA3 with a bad stop bit, line held low, then a good 0x3C.
    fe0 = fe_cnt;
    vr0 = vrise;
    send_frame(8'hA3, 1'b0);
    rxd = 1'b0;
    wait_cyc(40);
    chk("t3 busy in break", busy, 1);
    rxd = 1'b1;
    wait_cyc(CLKDIV);
    chk("t3 frame_err count", fe_cnt - fe0, 1);
    chk("t3 no valid for bad byte", vrise - vr0, 0);
    send_frame(8'h3C, 1'b1);
    wait_cyc(4);
    chk("t3 rx_valid", rx_valid, 1);
    chk("t3 rx_data", rx_data, 8'h3C);
    chk("t3 frame_err total", fe_cnt - fe0, 1);
    accept_pulse();
    wait_cyc(3);

    // 4: back-to-back 0x11 and 0x22 with no consumer; the second byte overruns.
    ov0 = ov_cnt;
    vr0 = vrise;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cyc(4);
    chk("t4 rx_data", rx_data, 8'h11);
    chk("t4 rx_valid", rx_valid, 1);
    chk("t4 overrun count", ov_cnt - ov0, 1);
    chk("t4 valid count", vrise - vr0, 1);
    accept_pulse();
    chk("t4 valid after accept", rx_valid, 0);
    wait_cyc(3);

    // 5: reset during data bit 3 of 0x9E, then a clean 0xF0.
    send_bits({1'b1, 8'h9E, 1'b0}, 4);
    wait_cyc(CLKDIV / 2);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    chk("t5 rst rx_valid", rx_valid, 0);
    chk("t5 rst rx_data", rx_data, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst frame_err", frame_err, 0);
    chk("t5 rst overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(20);
    vr0 = vrise;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hF0, 1'b1);
    wait_cyc(4);
    chk("t5 rx_data", rx_data, 8'hF0);
    chk("t5 valid count", vrise - vr0, 1);
    chk("t5 no errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    accept_pulse();
    wait_cyc(3);

    // 6: rx_ready tied high and zero-gap frames from the vector table.
    acc_q.delete();
    vr0 = vrise;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b1;
    foreach (vecs[i]) send_frame(vecs[i].byte_in, 1'b1);
    wait_cyc(4);
    rx_ready = 1'b0;
    chk("t6 valid pulses", vrise - vr0, 5);
    chk("t6 accepted count", acc_q.size(), 5);
    foreach (vecs[i]) begin
      exp_b = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      chk($sformatf("t6 byte %0d", i), exp_b, vecs[i].exp_data);
    end
    chk("t6 no overrun", ov_cnt - ov0, 0);
    chk("t6 no frame_err", fe_cnt - fe0, 0);
    chk("t6 idle at end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
